// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: bundles the two writeback request channels, the
// register-file write port and the busy flag shared by reg_wb_arbiter.
//   req0_*  ALU writeback channel (valid/idx/data in, ready out)
//   req1_*  load/store writeback channel (valid/idx/data in, ready out)
//   wr_*    registered register-file write port
//   busy    any holding register or output stage occupied
// Optional feature macro: WB_HAZARD_EN adds rd_reg_index_1/2 (to arbiter)
// and rd_pend_1/2 (from arbiter) for decode operand-read stalls.
// Modports: slave = arbiter side, master = writeback sources / reg_file side.
interface reg_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
);
    logic              req0_valid;
    logic [IDX_W-1:0]  req0_idx;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [IDX_W-1:0]  req1_idx;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_reg_index;
    logic [DATA_W-1:0] wr_reg_data;
    logic              busy;
`ifdef WB_HAZARD_EN
    logic [IDX_W-1:0]  rd_reg_index_1;
    logic [IDX_W-1:0]  rd_reg_index_2;
    logic              rd_pend_1;
    logic              rd_pend_2;
`endif

    modport slave (
        input  req0_valid, req0_idx, req0_data,
        output req0_ready,
        input  req1_valid, req1_idx, req1_data,
        output req1_ready,
        output wr_en, wr_reg_index, wr_reg_data, busy
`ifdef WB_HAZARD_EN
        ,
        input  rd_reg_index_1, rd_reg_index_2,
        output rd_pend_1, rd_pend_2
`endif
    );

    modport master (
        output req0_valid, req0_idx, req0_data,
        input  req0_ready,
        output req1_valid, req1_idx, req1_data,
        input  req1_ready,
        input  wr_en, wr_reg_index, wr_reg_data, busy
`ifdef WB_HAZARD_EN
        ,
        output rd_reg_index_1, rd_reg_index_2,
        input  rd_pend_1, rd_pend_2
`endif
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the single register-file write port between the ALU
// writeback (req0) and the load/store writeback (req1). Each source has a
// one-entry holding register; a round-robin arbiter drains one held entry per
// cycle into the registered wr_en / wr_reg_index / wr_reg_data outputs.
// Writes to index 0 are consumed but never issued, keeping r0 at zero.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  reg_wb_arbiter_if.slave (request channels, write port, busy,
//        and with WB_HAZARD_EN the rd_reg_index_k / rd_pend_k hazard query)
// Optional feature macro: WB_HAZARD_EN (pending-write hazard lookup).
module reg_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    reg_wb_arbiter_if.slave     bus
);

    logic              held0;
    logic              held1;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              xfer0;
    logic              xfer1;

    // Grant uses held state only, so ready never depends on valid.
    // last_grant == 1 means req1 won last, so req0 wins a tie.
    always_comb begin
        grant0         = held0 & (~held1 | last_grant);
        grant1         = held1 & (~held0 | ~last_grant);
        bus.req0_ready = ~rst & (~held0 | grant0);
        bus.req1_ready = ~rst & (~held1 | grant1);
        xfer0          = bus.req0_valid & bus.req0_ready;
        xfer1          = bus.req1_valid & bus.req1_ready;
        bus.busy       = held0 | held1 | bus.wr_en;
    end

    // Holding registers and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            held0            <= 1'b0;
            held1            <= 1'b0;
            idx0             <= '0;
            idx1             <= '0;
            data0            <= '0;
            data1            <= '0;
            last_grant       <= 1'b1;
            bus.wr_en        <= 1'b0;
            bus.wr_reg_index <= '0;
            bus.wr_reg_data  <= '0;
        end else begin
            if (grant0) begin
                bus.wr_en        <= (idx0 != '0);
                bus.wr_reg_index <= idx0;
                bus.wr_reg_data  <= data0;
                last_grant       <= 1'b0;
            end else if (grant1) begin
                bus.wr_en        <= (idx1 != '0);
                bus.wr_reg_index <= idx1;
                bus.wr_reg_data  <= data1;
                last_grant       <= 1'b1;
            end else begin
                bus.wr_en        <= 1'b0;
            end

            // A transfer in the draining edge refills the slot in place.
            if (xfer0) begin
                held0 <= 1'b1;
                idx0  <= bus.req0_idx;
                data0 <= bus.req0_data;
            end else if (grant0) begin
                held0 <= 1'b0;
            end

            if (xfer1) begin
                held1 <= 1'b1;
                idx1  <= bus.req1_idx;
                data1 <= bus.req1_data;
            end else if (grant1) begin
                held1 <= 1'b0;
            end
        end
    end

`ifdef WB_HAZARD_EN
    // A read is pending while its register sits in a holding slot or is
    // being written this cycle; r0 never stalls.
    always_comb begin
        bus.rd_pend_1 = (bus.rd_reg_index_1 != '0) &
                        ((held0 & (idx0 == bus.rd_reg_index_1)) |
                         (held1 & (idx1 == bus.rd_reg_index_1)) |
                         (bus.wr_en & (bus.wr_reg_index == bus.rd_reg_index_1)));
        bus.rd_pend_2 = (bus.rd_reg_index_2 != '0) &
                        ((held0 & (idx0 == bus.rd_reg_index_2)) |
                         (held1 & (idx1 == bus.rd_reg_index_2)) |
                         (bus.wr_en & (bus.wr_reg_index == bus.rd_reg_index_2)));
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: self-checking bench for reg_wb_arbiter. Directed
// scenarios plus a randomized run compared against a transaction-level
// reference model (one pending slot per source, round-robin preference).
// Build with WB_HAZARD_EN defined to also exercise the hazard outputs.
module tb_reg_wb_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned NREG   = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();
    reg_wb_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Register file fed by the DUT write port.
    logic [DATA_W-1:0] rf [NREG];
    always @(posedge clk) if (bus.wr_en) rf[bus.wr_reg_index] <= bus.wr_reg_data;

    // Reference model: pending entry per source, which source is owed the
    // next tie, and the write the register file sees this cycle.
    bit                m_full [2] = '{0, 0};
    logic [IDX_W-1:0]  m_idx  [2] = '{'0, '0};
    logic [DATA_W-1:0] m_data [2] = '{'0, '0};
    int                m_owed = 0;
    bit                m_en = 1'b0;
    logic [IDX_W-1:0]  m_oidx = '0;
    logic [DATA_W-1:0] m_odata = '0;

    bit                s_v [2];
    logic [IDX_W-1:0]  s_i [2];
    logic [DATA_W-1:0] s_d [2];
    bit                s_rst;
    int                m_pick;
    bit                exp_rdy [2];

    function automatic int choose();
        if (m_full[0] && m_full[1]) return m_owed;
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit model_pend(input logic [IDX_W-1:0] r);
        if (r == '0) return 1'b0;
        return (m_full[0] && m_idx[0] == r) || (m_full[1] && m_idx[1] == r) ||
               (m_en && m_oidx == r);
    endfunction

    // Drive one cycle of inputs (just after negedge) and predict ready.
    task automatic apply(input bit v0, input int i0, input int d0,
                         input bit v1, input int i1, input int d1, input bit r);
        bus.req0_valid = v0; bus.req0_idx = IDX_W'(i0); bus.req0_data = DATA_W'(d0);
        bus.req1_valid = v1; bus.req1_idx = IDX_W'(i1); bus.req1_data = DATA_W'(d1);
        rst = r;
        s_v[0] = v0; s_i[0] = IDX_W'(i0); s_d[0] = DATA_W'(d0);
        s_v[1] = v1; s_i[1] = IDX_W'(i1); s_d[1] = DATA_W'(d1);
        s_rst = r;
        m_pick = choose();
        for (int k = 0; k < 2; k++) exp_rdy[k] = !r && (!m_full[k] || m_pick == k);
        #1;
    endtask

    // Advance one clock and the model with it; returns at negedge + 1.
    task automatic tick();
        @(posedge clk);
        if (s_rst) begin
            m_full = '{0, 0};
            m_owed = 0;
            m_en = 1'b0; m_oidx = '0; m_odata = '0;
        end else begin
            if (m_pick >= 0) begin
                m_en = (m_idx[m_pick] != '0);
                m_oidx = m_idx[m_pick];
                m_odata = m_data[m_pick];
                m_owed = 1 - m_pick;
                m_full[m_pick] = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (s_v[k] && exp_rdy[k]) begin
                    m_full[k] = 1'b1; m_idx[k] = s_i[k]; m_data[k] = s_d[k];
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 1); tick();
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0_in_rst: got %b expected 0", bus.req0_ready); end
        tick(); tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        checks++; if (bus.wr_reg_index !== '0) begin errors++; $display("FAIL reset_index: got %0d expected 0", bus.wr_reg_index); end
        checks++; if (bus.wr_reg_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.wr_reg_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        apply(1, 5, 1234, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_latency: got wr_en=%b busy=%b expected 0/1", bus.wr_en, bus.busy); end
        tick();
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_reg_index !== 4'd5 || bus.wr_reg_data !== 32'd1234) begin
            errors++; $display("FAIL single_write: got en=%b idx=%0d data=%0d expected 1/5/1234", bus.wr_en, bus.wr_reg_index, bus.wr_reg_data); end
        n = 1;
        for (int t = 0; t < 4; t++) begin tick(); if (bus.wr_en) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL single_pulse_count: got %0d expected 1", n); end
        checks++; if (rf[5] !== 32'd1234) begin errors++; $display("FAIL single_rf_r5: got %0d expected 1234", rf[5]); end
    endtask

    task automatic test_same_cycle();
        int seq [$];
        do_reset();
        apply(1, 3, 11, 1, 7, 22, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin tick(); if (bus.wr_en) seq.push_back(int'(bus.wr_reg_index)); end
        checks++; if (seq.size() != 2 || seq[0] != 3 || seq[1] != 7) begin
            errors++; $display("FAIL same_cycle_order: got %p expected '{3, 7}", seq); end
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        k = 0;
        for (int t = 1; t <= 10; t++) begin
            if (t <= 6) apply(1, 1 + (k % 7), int'($urandom), 1, 8 + (k % 8), int'($urandom), 0);
            else apply(0, 0, 0, 0, 0, 0, 0);
            k++;
            tick();
            // Writes occupy edges 2..8; source alternates starting with req0.
            checks++;
            if (bus.wr_en !== ((t >= 2 && t <= 8) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL b2b_wr_en t=%0d: got %b", t, bus.wr_en);
            end else if (bus.wr_en && ((bus.wr_reg_index >= 4'd8) !== (t % 2 == 1) || bus.wr_reg_data !== m_odata)) begin
                errors++; $display("FAIL b2b_source t=%0d: got idx=%0d data=%0h expected src%0d data=%0h", t, bus.wr_reg_index, bus.wr_reg_data, t % 2, m_odata);
            end
        end
    endtask

    task automatic test_idx_zero();
        int n;
        do_reset();
        apply(1, 2, 77, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 1, 0, 2431, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL idx0_ready: got %b expected 1", bus.req1_ready); end
        n = 0;
        for (int t = 0; t < 4; t++) begin tick(); if (bus.wr_en && bus.wr_reg_index == '0) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL idx0_no_write: got %0d writes expected 0", n); end
        checks++; if (rf[0] !== '0) begin errors++; $display("FAIL idx0_r0: got %0d expected 0", rf[0]); end
        // Zero-index grant to req1 still makes req0 win the next tie.
        apply(1, 4, 40, 1, 6, 60, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_reg_index !== 4'd4) begin
            errors++; $display("FAIL idx0_rr_update: got en=%b idx=%0d expected 1/4", bus.wr_en, bus.wr_reg_index); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        apply(1, 4, 444, 1, 6, 666, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 1);
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready_low: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
        tick();
        checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: got wr_en=%b busy=%b expected 0/0", bus.wr_en, bus.busy); end
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_ready_back: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
        n = 0;
        for (int t = 0; t < 3; t++) begin tick(); if (bus.wr_en) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL rstmid_no_write: got %0d expected 0", n); end
    endtask

`ifdef WB_HAZARD_EN
    task automatic test_hazard();
        do_reset();
        apply(1, 9, 99, 0, 0, 0, 0); tick();
        bus.rd_reg_index_1 = 4'd9; bus.rd_reg_index_2 = 4'd0;
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.rd_pend_1, bus.rd_pend_2} !== 2'b10) begin errors++; $display("FAIL hazard_held: got %b expected 10", {bus.rd_pend_1, bus.rd_pend_2}); end
        tick();
        checks++; if (bus.wr_en !== 1'b1 || bus.rd_pend_1 !== 1'b1) begin errors++; $display("FAIL hazard_wr_cycle: got en=%b pend=%b expected 1/1", bus.wr_en, bus.rd_pend_1); end
        tick();
        checks++; if (bus.rd_pend_1 !== 1'b0) begin errors++; $display("FAIL hazard_drop: got %b expected 0", bus.rd_pend_1); end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
`ifdef WB_HAZARD_EN
            bus.rd_reg_index_1 = IDX_W'($urandom_range(0, 5));
            bus.rd_reg_index_2 = IDX_W'($urandom_range(0, 5));
`endif
            apply(($urandom % 3) != 0, int'($urandom_range(0, 5)), int'($urandom),
                  ($urandom % 3) != 0, int'($urandom_range(0, 5)), int'($urandom),
                  ($urandom % 50) == 0);
            checks++; if (bus.req0_ready !== exp_rdy[0] || bus.req1_ready !== exp_rdy[1]) begin
                errors++; $display("FAIL rand_ready t=%0d: got %b%b expected %b%b", t, bus.req0_ready, bus.req1_ready, exp_rdy[0], exp_rdy[1]); end
            tick();
            checks++; if (bus.wr_en !== m_en || bus.busy !== (m_full[0] | m_full[1] | m_en)) begin
                errors++; $display("FAIL rand_en_busy t=%0d: got %b/%b expected %b/%b", t, bus.wr_en, bus.busy, m_en, m_full[0] | m_full[1] | m_en); end
            if (m_en) begin
                checks++; if (bus.wr_reg_index !== m_oidx || bus.wr_reg_data !== m_odata) begin
                    errors++; $display("FAIL rand_write t=%0d: got %0d/%0h expected %0d/%0h", t, bus.wr_reg_index, bus.wr_reg_data, m_oidx, m_odata); end
            end
`ifdef WB_HAZARD_EN
            checks++; if (bus.rd_pend_1 !== model_pend(bus.rd_reg_index_1) || bus.rd_pend_2 !== model_pend(bus.rd_reg_index_2)) begin
                errors++; $display("FAIL rand_pend t=%0d: got %b%b expected %b%b", t, bus.rd_pend_1, bus.rd_pend_2, model_pend(bus.rd_reg_index_1), model_pend(bus.rd_reg_index_2)); end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NREG); i++) rf[i] = '0;
`ifdef WB_HAZARD_EN
        bus.rd_reg_index_1 = '0;
        bus.rd_reg_index_2 = '0;
`endif
        test_reset();
        test_single();
        test_same_cycle();
        test_back_to_back();
        test_idx_zero();
        test_reset_mid();
`ifdef WB_HAZARD_EN
        test_hazard();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
